// File: rtl/pe_instr_encoder_pkg.sv
// Shared constants for the PE instruction bus: field widths, op codes and FSM states.
// The decoder side imports the same package so both ends agree on the encoding.
package pe_instr_encoder_pkg;

    localparam int DEF_LOG_B       = 3;
    localparam int DEF_OP_WIDTH    = 3;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_INSTR_WIDTH = 1 + DEF_LOG_B + DEF_OP_WIDTH;

    localparam logic [DEF_OP_WIDTH-1:0] OP_READ0   = 3'd0;
    localparam logic [DEF_OP_WIDTH-1:0] OP_READ1   = 3'd1;
    localparam logic [DEF_OP_WIDTH-1:0] OP_COMPUTE = 3'd2;
    localparam logic [DEF_OP_WIDTH-1:0] OP_FORWARD = 3'd3;
    localparam logic [DEF_OP_WIDTH-1:0] OP_IDLE    = 3'd7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/pe_instr_encoder_req_fifo.sv
// Synchronous request FIFO (power-of-two depth) holding burst requests
// until the issue FSM expands them.
module pe_instr_encoder_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_instr_encoder.sv
// Issue end of the PE instruction bus: expands queued burst requests into one
// {fwd, id, op} word per non-stalled cycle, with IDLE filler in between.
module pe_instr_encoder
    import pe_instr_encoder_pkg::*;
#(
    parameter int logB       = DEF_LOG_B,
    parameter int OP_WIDTH   = DEF_OP_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [OP_WIDTH-1:0]          req_op,
    input  logic [logB-1:0]              req_id,
    input  logic [logB:0]                req_count,
    input  logic                         req_fwd,
    input  logic                         stall,
    output logic [1+logB+OP_WIDTH-1:0]   instr_out,
    output logic                         instr_vld,
    output logic                         busy,
    output state_e                       o_dbg_state
);

    localparam int INSTR_WIDTH = 1 + logB + OP_WIDTH;
    localparam int ENTRY_WIDTH = 1 + OP_WIDTH + logB + logB + 1;
    localparam logic [INSTR_WIDTH-1:0] IDLE_WORD = {1'b0, {logB{1'b0}}, OP_WIDTH'(OP_IDLE)};
    localparam logic [logB:0] CNT_ONE = (logB+1)'(1);

    logic [ENTRY_WIDTH-1:0] w_fifo_rdata;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic                   w_head_fwd;
    logic [OP_WIDTH-1:0]    w_head_op;
    logic [logB-1:0]        w_head_id;
    logic [logB:0]          w_head_count;

    state_e                 r_state,   w_state_nxt;
    logic [logB-1:0]        r_cur_id,  w_cur_id_nxt;
    logic [logB:0]          r_remain,  w_remain_nxt;
    logic [OP_WIDTH-1:0]    r_op,      w_op_nxt;
    logic                   r_fwd,     w_fwd_nxt;
    logic [INSTR_WIDTH-1:0] r_instr,   w_instr_nxt;
    logic                   r_vld,     w_vld_nxt;

    // Handshake: a request transfers on a cycle where req_valid & req_ready are
    // both high; req_ready depends only on FIFO occupancy, never on req_valid.
    assign req_ready = ~w_fifo_full;

    pe_instr_encoder_req_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (req_valid),
        .i_data  ({req_fwd, req_op, req_id, req_count}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_head_fwd, w_head_op, w_head_id, w_head_count} = w_fifo_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_id_nxt = r_cur_id;
        w_remain_nxt = r_remain;
        w_op_nxt     = r_op;
        w_fwd_nxt    = r_fwd;
        w_instr_nxt  = r_instr;
        w_vld_nxt    = r_vld;
        w_pop        = 1'b0;
        if (!stall) begin
            w_instr_nxt = IDLE_WORD;
            w_vld_nxt   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop = 1'b1;
                        // Zero-count entries are consumed without issuing anything.
                        if (w_head_count != '0) begin
                            w_instr_nxt  = {w_head_fwd, w_head_id, w_head_op};
                            w_vld_nxt    = 1'b1;
                            w_cur_id_nxt = w_head_id + 1'b1;
                            w_remain_nxt = w_head_count - 1'b1;
                            w_op_nxt     = w_head_op;
                            w_fwd_nxt    = w_head_fwd;
                            w_state_nxt  = (w_head_count == CNT_ONE) ? S_IDLE : S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    w_instr_nxt  = {r_fwd, r_cur_id, r_op};
                    w_vld_nxt    = 1'b1;
                    w_cur_id_nxt = r_cur_id + 1'b1;
                    w_remain_nxt = r_remain - 1'b1;
                    if (r_remain == CNT_ONE) begin
                        w_state_nxt = S_IDLE;
                        // Load the next burst now so its first word follows without a gap.
                        if (!w_fifo_empty) begin
                            w_pop        = 1'b1;
                            w_cur_id_nxt = w_head_id;
                            w_remain_nxt = w_head_count;
                            w_op_nxt     = w_head_op;
                            w_fwd_nxt    = w_head_fwd;
                            if (w_head_count != '0) w_state_nxt = S_ISSUE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cur_id <= '0;
            r_remain <= '0;
            r_op     <= '0;
            r_fwd    <= 1'b0;
            r_instr  <= IDLE_WORD;
            r_vld    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_id <= w_cur_id_nxt;
            r_remain <= w_remain_nxt;
            r_op     <= w_op_nxt;
            r_fwd    <= w_fwd_nxt;
            r_instr  <= w_instr_nxt;
            r_vld    <= w_vld_nxt;
        end
    end

    assign instr_out   = r_instr;
    assign instr_vld   = r_vld;
    assign busy        = ~w_fifo_empty | (r_state == S_ISSUE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pe_instr_encoder.sv
// Bench for pe_instr_encoder: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-of-words model.
module tb_pe_instr_encoder;
    import pe_instr_encoder_pkg::*;

    localparam int LB = DEF_LOG_B;
    localparam int OW = DEF_OP_WIDTH;
    localparam int IW = DEF_INSTR_WIDTH;
    localparam int B  = 1 << LB;
    localparam logic [IW-1:0] IDLE_W = {1'b0, {LB{1'b0}}, OP_IDLE};

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_op;
    logic [LB-1:0] req_id;
    logic [LB:0]   req_count;
    logic          req_fwd;
    logic          stall;
    logic [IW-1:0] instr_out;
    logic          instr_vld;
    logic          busy;
    state_e        dbg_state;

    logic [IW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    pe_instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_id      (req_id),
        .req_count   (req_count),
        .req_fwd     (req_fwd),
        .stall       (stall),
        .instr_out   (instr_out),
        .instr_vld   (instr_vld),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk_word(input logic fwd, input int id, input logic [OW-1:0] op);
        logic [LB-1:0] wid;
        wid = LB'(id % B);
        return {fwd, wid, op};
    endfunction

    // A burst is simply count words with consecutive ids modulo B.
    task automatic add_burst(input logic [OW-1:0] op, input int id, input int cnt, input logic fwd);
        for (int i = 0; i < cnt; i++) exp_q.push_back(mk_word(fwd, id + i, op));
    endtask

    // ---------------- driver ----------------
    task automatic push_req(input logic [OW-1:0] op, input int id, input int cnt, input logic fwd);
        int k;
        @(negedge clk);
        req_op    = op;
        req_id    = LB'(id);
        req_count = (LB+1)'(cnt);
        req_fwd   = fwd;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got ready=0, expected ready=1");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_word(input string name, input logic [IW-1:0] exp);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!instr_vld && k < 50);
        check(name, instr_out, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [IW-1:0] prev_out = IDLE_W;
    logic          prev_vld = 1'b0;

    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        logic          s_stall;
        logic          s_push;
        logic [OW-1:0] s_op;
        logic [LB-1:0] s_id;
        logic [LB:0]   s_cnt;
        logic          s_fwd;
        s_stall = stall;
        s_push  = rst_n && req_valid && req_ready;
        s_op    = req_op;
        s_id    = req_id;
        s_cnt   = req_count;
        s_fwd   = req_fwd;
        #1;
        if (!rst_n) begin
            check("sb_reset_out", instr_out, IDLE_W);
            check("sb_reset_vld", instr_vld, 1'b0);
        end else if (s_stall) begin
            check("sb_hold_out", instr_out, prev_out);
            check("sb_hold_vld", instr_vld, prev_vld);
        end else if (instr_vld) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_word: got %0h, expected no word", instr_out);
            end else begin
                check("sb_word", instr_out, exp_q.pop_front());
            end
        end else begin
            check("sb_filler", instr_out, IDLE_W);
        end
        prev_out = instr_out;
        prev_vld = instr_vld;
        if (s_push) add_burst(s_op, int'(s_id), int'(s_cnt), s_fwd);
    end

    // ---------------- stimulus ----------------
    initial begin
        int run;
        int k;
        int n_after;
        logic prev_ready;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_id = '0;
        req_count = '0; req_fwd = 1'b0; stall = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_instr_out", instr_out, IDLE_W);
        check("rst_instr_vld", instr_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;

        // Single READ0 id=2 count=3: words on consecutive cycles, then filler
        push_req(OP_READ0, 2, 3, 1'b0);
        @(posedge clk); #1;
        check("single_w0", instr_out, {1'b0, 3'd2, OP_READ0});
        check("single_v0", instr_vld, 1'b1);
        @(posedge clk); #1;
        check("single_w1", instr_out, {1'b0, 3'd3, OP_READ0});
        @(posedge clk); #1;
        check("single_w2", instr_out, {1'b0, 3'd4, OP_READ0});
        check("single_busy_done", busy, 1'b0);
        @(posedge clk); #1;
        check("single_filler", instr_out, IDLE_W);
        check("single_filler_vld", instr_vld, 1'b0);

        // Wrap, zero-count drop, then the following request
        fork
            begin
                push_req(OP_READ1, 6, 4, 1'b1);
                push_req(OP_READ0, 3, 0, 1'b0);
                push_req(OP_FORWARD, 1, 2, 1'b0);
                push_req(OP_COMPUTE, 5, 1, 1'b0);
            end
            begin
                wait_word("wrap_id6", {1'b1, 3'd6, OP_READ1});
                wait_word("wrap_id7", {1'b1, 3'd7, OP_READ1});
                wait_word("wrap_id0", {1'b1, 3'd0, OP_READ1});
                wait_word("wrap_id1", {1'b1, 3'd1, OP_READ1});
                wait_word("after_zero_w0", {1'b0, 3'd1, OP_FORWARD});
                wait_word("after_zero_w1", {1'b0, 3'd2, OP_FORWARD});
                wait_word("compute_w", {1'b0, 3'd5, OP_COMPUTE});
            end
        join
        repeat (3) @(posedge clk);

        // Stall on the 2nd word of a 3-word burst for 3 cycles
        push_req(OP_READ0, 4, 3, 1'b0);
        @(posedge clk); #1;
        check("stall_w0", instr_out, {1'b0, 3'd4, OP_READ0});
        @(posedge clk); #1;
        check("stall_w1", instr_out, {1'b0, 3'd5, OP_READ0});
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_held", instr_out, {1'b0, 3'd5, OP_READ0});
            check("stall_held_vld", instr_vld, 1'b1);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        check("stall_w2", instr_out, {1'b0, 3'd6, OP_READ0});
        @(posedge clk); #1;
        check("stall_filler_vld", instr_vld, 1'b0);

        // Back-pressure: 4 requests fill the FIFO while stalled
        @(negedge clk);
        stall = 1'b1;
        push_req(OP_READ0, 0, 2, 1'b0);
        push_req(OP_READ1, 3, 3, 1'b1);
        push_req(OP_COMPUTE, 0, 1, 1'b0);
        push_req(OP_FORWARD, 7, 2, 1'b1);
        check("bp_ready_full", req_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_no_issue", instr_vld, 1'b0);
        stall = 1'b0;
        run = 0;
        fork
            push_req(OP_READ1, 2, 3, 1'b0);
            begin
                k = 0;
                do begin
                    @(posedge clk); #1;
                    k++;
                end while (!instr_vld && k < 20);
                while (instr_vld && run < 40) begin
                    run++;
                    @(posedge clk); #1;
                end
            end
        join
        check("bp_no_bubble_run", run, 11);

        // Reset in the middle of a burst with another request queued
        push_req(OP_READ1, 0, 8, 1'b0);
        push_req(OP_READ0, 1, 2, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", instr_out, IDLE_W);
        check("mid_rst_vld", instr_vld, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_state", dbg_state, S_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_after = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (instr_vld) n_after++;
        end
        check("post_rst_no_words", n_after, 0);
        check("post_rst_busy", busy, 1'b0);

        // Randomized traffic with random stalls
        prev_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!(req_valid && !prev_ready)) begin
                req_valid = ($urandom_range(0, 99) < 40);
                req_op    = OW'($urandom_range(0, 3));
                req_id    = LB'($urandom_range(0, B - 1));
                req_count = (LB+1)'($urandom_range(0, B));
                req_fwd   = 1'($urandom_range(0, 1));
            end
            stall = ($urandom_range(0, 99) < 25);
            prev_ready = req_ready;
        end
        @(negedge clk);
        req_valid = 1'b0;
        stall = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_busy", busy, 1'b0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_vld", instr_vld, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
